sha256_message_scheduler: RTL and testbench

Streaming SHA-256 message-schedule generator that sits directly upstream of the round-operations/hash-register stage. It accepts one 512-bit padded message block and emits the 64 schedule words W0..W63, one per cycle, in round order, with a valid/ready handshake. Its word output feeds `message_schedule_value` of the round stage. Its start pulse drives that stage's `input_ready`.

---
 rtl/sha256_message_scheduler.sv | 116 +++++++++++
 tb/tb_sha256_message_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_message_scheduler.sv
// Streaming SHA-256 message schedule: loads one padded block, emits W0..W63 with valid/ready.
// Optional `SCHED_BYTE_SWAP_EN byte-reverses each input word on load (little-endian hosts).
module sha256_message_scheduler #(
    parameter int WORD_SIZE = 32,
    parameter int ROUNDS    = 64,
    localparam int IDX_W    = $clog2(ROUNDS)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [WORD_SIZE*16-1:0] block_in,
    input  logic                   block_valid,
    output logic                   block_ready,
    output logic [WORD_SIZE-1:0]   message_schedule_value,
    output logic [IDX_W-1:0]       message_schedule_index,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic                   w_last,
    output logic                   round_start
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] T_PEN  = IDX_W'(ROUNDS - 2);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] win_q [16];
    logic [WORD_SIZE-1:0] win_d [16];
    logic [IDX_W-1:0]     t_q, t_d;
    logic                 w_valid_q, w_valid_d;
    logic                 w_last_q, w_last_d;
    logic                 round_start_q, round_start_d;
    logic [WORD_SIZE-1:0] new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] load_word(input logic [31:0] x);
`ifdef SCHED_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        w_valid_d     = w_valid_q;
        w_last_d      = w_last_q;
        round_start_d = 1'b0;
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
        new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

        case (state_q)
            IDLE: begin
                if (block_valid) begin
                    for (int i = 0; i < 16; i++)
                        win_d[i] = load_word(block_in[WORD_SIZE*(15-i) +: WORD_SIZE]);
                    t_d           = '0;
                    w_valid_d     = 1'b1;
                    w_last_d      = 1'b0;
                    round_start_d = 1'b1;
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    if (t_q == T_LAST) begin
                        // final beat: no shift needed, just release the window
                        state_d   = IDLE;
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                    end else begin
                        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                        win_d[15] = new_word;
                        t_d       = t_q + IDX_W'(1);
                        w_last_d  = (t_q == T_PEN);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q       <= IDLE;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
            t_q           <= '0;
            w_valid_q     <= 1'b0;
            w_last_q      <= 1'b0;
            round_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
            t_q           <= t_d;
            w_valid_q     <= w_valid_d;
            w_last_q      <= w_last_d;
            round_start_q <= round_start_d;
        end
    end

    assign block_ready            = (state_q == IDLE);
    assign message_schedule_value = win_q[0];
    assign message_schedule_index = t_q;
    assign w_valid                = w_valid_q;
    assign w_last                 = w_last_q;
    assign round_start            = round_start_q;

endmodule

// File: tb/tb_sha256_message_scheduler.sv
// Directed bench for sha256_message_scheduler using the "abc" block with known schedule words.
// Build with `SCHED_BYTE_SWAP_EN to feed byte-reversed words to a byte-swapping DUT.
module tb_sha256_message_scheduler;

    logic         clock = 1'b0;
    logic         clear;
    logic [511:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic [31:0]  message_schedule_value;
    logic [5:0]   message_schedule_index;
    logic         w_valid;
    logic         w_ready;
    logic         w_last;
    logic         round_start;

    int n_checks = 0;
    int n_pass   = 0;

    logic [511:0] abc_blk;
    logic [511:0] blk2;

    sha256_message_scheduler dut (
        .clock                  (clock),
        .clear                  (clear),
        .block_in               (block_in),
        .block_valid            (block_valid),
        .block_ready            (block_ready),
        .message_schedule_value (message_schedule_value),
        .message_schedule_index (message_schedule_index),
        .w_valid                (w_valid),
        .w_ready                (w_ready),
        .w_last                 (w_last),
        .round_start            (round_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] pw(input logic [31:0] x);
`ifdef SCHED_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    // hand-derived "abc" schedule words
    function automatic bit known_w(input int t, output logic [31:0] e);
        known_w = 1'b1;
        case (t)
            0:       e = 32'h61626380;
            15:      e = 32'h00000018;
            16:      e = 32'h61626380;
            17:      e = 32'h000F0000;
            18:      e = 32'h7DA86405;
            19:      e = 32'h600003C6;
            63:      e = 32'h12B1EDEB;
            default: begin e = 32'h0; known_w = (t >= 1 && t <= 14); end
        endcase
    endfunction

    // called at a negedge with the DUT idle; returns at the negedge showing W0
    task automatic offer(input logic [511:0] b, input string nm);
        int n = 0;
        block_in    = b;
        block_valid = 1'b1;
        while (!block_ready && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) check({nm, " accept timeout"}, 32'(n), 32'(0));
        @(negedge clock);
        block_valid = 1'b0;
    endtask

    task automatic stream(input int stall_at, input int stall_len, input string nm);
        int beats = 0, rs = 0, last_err = 0, idx_err = 0, cyc = 0, stalled = 0;
        bit done = 1'b0;
        logic [31:0] e;
        while (!done && cyc < 400) begin
            if (round_start) rs++;
            if (w_valid) begin
                if (int'(message_schedule_index) == stall_at && stalled < stall_len) begin
                    if (stalled > 0) begin
                        void'(known_w(stall_at, e));
                        check($sformatf("%s frozen value s%0d", nm, stalled), message_schedule_value, e);
                        check($sformatf("%s frozen index s%0d", nm, stalled),
                              32'(message_schedule_index), 32'(stall_at));
                    end
                    w_ready = 1'b0;
                    stalled++;
                end else begin
                    w_ready = 1'b1;
                    if (int'(message_schedule_index) != beats) idx_err++;
                    if (w_last != (beats == 63)) last_err++;
                    if (known_w(beats, e))
                        check($sformatf("%s W%0d", nm, beats), message_schedule_value, e);
                    beats++;
                    if (beats == 64) done = 1'b1;
                end
            end
            @(negedge clock);
            cyc++;
        end
        w_ready = 1'b1;
        check({nm, " beats"}, 32'(beats), 32'd64);
        check({nm, " round_start pulses"}, 32'(rs), 32'd1);
        check({nm, " index sequence errs"}, 32'(idx_err), 32'd0);
        check({nm, " w_last errs"}, 32'(last_err), 32'd0);
        check({nm, " idle after last"}, {30'd0, block_ready, w_valid}, 32'b10);
    endtask

    logic        tr_v   [150];
    logic [5:0]  tr_idx [150];
    logic        tr_last[150];
    logic [31:0] tr_val [150];

    initial begin
        int c_last, nv, n;
        bit swapped, dropped;
        abc_blk     = {pw(32'h61626380), 448'h0, pw(32'h00000018)};
        blk2        = {pw(32'h00000001), 480'h0};
        clear       = 1'b0;
        block_valid = 1'b0;
        block_in    = '0;
        w_ready     = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        check("reset block_ready", 32'(block_ready), 32'd1);
        check("reset w_valid", 32'(w_valid), 32'd0);
        check("reset w_last", 32'(w_last), 32'd0);
        check("reset round_start", 32'(round_start), 32'd0);
        check("reset value", message_schedule_value, 32'h0);
        check("reset index", 32'(message_schedule_index), 32'd0);

        // reset and block_valid on the same edge: reset wins
        clear = 1'b0; block_valid = 1'b1; block_in = abc_blk;
        @(negedge clock);
        clear = 1'b1; block_valid = 1'b0;
        check("reset beats load w_valid", 32'(w_valid), 32'd0);
        @(negedge clock);
        check("reset beats load stays idle", {30'd0, block_ready, w_valid}, 32'b10);

        offer(abc_blk, "abc");
        check("abc first beat round_start", 32'(round_start), 32'd1);
        stream(-1, 0, "abc");

        offer(abc_blk, "bp");
        stream(10, 5, "bp");

        // back-to-back: block_valid stays high, second block swapped in during RUN
        block_in = abc_blk; block_valid = 1'b1; w_ready = 1'b1;
        swapped = 1'b0; dropped = 1'b0; c_last = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            tr_v[i] = w_valid; tr_idx[i] = message_schedule_index;
            tr_last[i] = w_last; tr_val[i] = message_schedule_value;
            if (w_valid && !swapped) begin block_in = blk2; swapped = 1'b1; end
            if (w_valid && w_last && c_last < 0) c_last = i;
            if (c_last >= 0 && i > c_last && w_valid && !dropped) begin
                block_valid = 1'b0; dropped = 1'b1;
            end
        end
        block_valid = 1'b0;
        check("b2b w_last found", 32'(c_last >= 0), 32'd1);
        if (c_last >= 0 && c_last + 3 < 150) begin
            nv = 0;
            for (int i = 0; i <= c_last; i++) if (tr_v[i]) nv++;
            check("b2b first block beats", 32'(nv), 32'd64);
            check("b2b bubble", 32'(tr_v[c_last+1]), 32'd0);
            check("b2b second start valid", 32'(tr_v[c_last+2]), 32'd1);
            check("b2b second start index", 32'(tr_idx[c_last+2]), 32'd0);
            check("b2b second W0", tr_val[c_last+2], 32'h00000001);
            check("b2b second W1", tr_val[c_last+3], 32'h00000000);
            check("b2b second no last", 32'(tr_last[c_last+2]), 32'd0);
        end
        n = 0;
        while (!block_ready && n < 200) begin @(negedge clock); n++; end
        check("b2b drain", 32'(block_ready), 32'd1);

        // mid-run reset at index 30
        offer(abc_blk, "mid");
        n = 0;
        while (!(w_valid && message_schedule_index == 6'd30) && n < 100) begin
            @(negedge clock); n++;
        end
        check("mid reached index 30", 32'(message_schedule_index), 32'd30);
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        check("mid reset w_valid", 32'(w_valid), 32'd0);
        check("mid reset index", 32'(message_schedule_index), 32'd0);
        check("mid reset w_last", 32'(w_last), 32'd0);
        check("mid reset value", message_schedule_value, 32'h0);
        check("mid reset block_ready", 32'(block_ready), 32'd1);
        offer(abc_blk, "after");
        stream(-1, 0, "after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
